dec_syndrome: RTL

- Front-end stage of the decoder datapath.
- Accepts a received codeword and its work mode over a valid/ready handshake, then zero-masks bits above the mode's codeword length.
- Computes the parity-check syndrome s = H·cᵀ over GF(2) and presents codeword, syndrome and mode, aligned, to the downstream check/correct stage.
- Two-stage registered pipeline with full-throughput backpressure.

---
 rtl/dec_syndrome.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/dec_syndrome.sv
`default_nettype none
// ============================================================================
// Module   : dec_syndrome
// Brief    : Decoder front end. Masks the codeword to its mode length and
//            computes the GF(2) syndrome in a 2-stage valid/ready pipeline.
//            Optional: SYND_ERR_INJECT_EN adds an inject_mask input.
// Revision : 1.0
// ============================================================================
module dec_syndrome #(
  parameter int MAX_CODEWORD_WIDTH = 32,
  parameter int MAX_INFO_WIDTH     = 26,
  parameter int MAX_PARITY_WIDTH   = MAX_CODEWORD_WIDTH - MAX_INFO_WIDTH,
  parameter int AMBA_WORD          = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [MAX_CODEWORD_WIDTH-1:0] data_in,
`ifdef SYND_ERR_INJECT_EN
  input  logic [MAX_CODEWORD_WIDTH-1:0] inject_mask,
`endif
  input  logic [AMBA_WORD-1:0]          work_mod,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
  output logic [MAX_PARITY_WIDTH-1:0]   s_vector,
  output logic [AMBA_WORD-1:0]          work_mod_out,
  output logic                          mode_err
);

  localparam int c_cw = MAX_CODEWORD_WIDTH;
  localparam int c_pw = MAX_PARITY_WIDTH;

  // Parity-check rows, bit j = column j; columns above a mode's length are 0.
  function automatic logic [31:0] h_row(input logic [1:0] m, input int r);
    logic [31:0] v;
    v = '0;
    case (m)
      2'd0: case (r)
        0: v = 32'h0000_00B1;
        1: v = 32'h0000_00D2;
        2: v = 32'h0000_00E4;
        3: v = 32'h0000_00FF;
        default: v = '0;
      endcase
      2'd1: case (r)
        0: v = 32'h0000_AB61;
        1: v = 32'h0000_CDA2;
        2: v = 32'h0000_F1C4;
        3: v = 32'h0000_FE08;
        4: v = 32'h0000_FFFF;
        default: v = '0;
      endcase
      2'd2: case (r)
        0: v = 32'hAAAB_56C1;
        1: v = 32'hCCCD_9B42;
        2: v = 32'hF0F1_E384;
        3: v = 32'hFF01_FC08;
        4: v = 32'hFFFE_0010;
        5: v = 32'hFFFF_FFFF;
        default: v = '0;
      endcase
      default: v = '0;
    endcase
    return v;
  endfunction

  logic            s1_valid_q, s2_valid_q;
  logic [c_cw-1:0] s1_data_q, s1_data_d, s2_data_q;
  logic [AMBA_WORD-1:0] s1_wm_q, s2_wm_q;
  logic            s1_err_q, s1_err_d, s2_err_q;
  logic [c_pw-1:0] s2_syn_q, syn_d;

  logic            w_s2_adv, w_s1_adv, w_accept;
  logic [c_cw-1:0] w_raw, w_mask;
  logic [31:0]     w_row;
  int              w_len;

  assign w_s2_adv = !s2_valid_q || out_ready;
  assign w_s1_adv = s1_valid_q && w_s2_adv;
  assign in_ready = !s1_valid_q || w_s2_adv;
  assign w_accept = in_valid && in_ready;

`ifdef SYND_ERR_INJECT_EN
  assign w_raw = data_in ^ inject_mask;
`else
  assign w_raw = data_in;
`endif

  always_comb begin
    w_len    = 0;
    w_mask   = '0;
    s1_err_d = 1'b0;
    case (work_mod)
      AMBA_WORD'(0): w_len = 8;
      AMBA_WORD'(1): w_len = 16;
      AMBA_WORD'(2): w_len = 32;
      default:       w_len = 0;
    endcase
    // Unknown modes and modes wider than this instance are both illegal.
    if (work_mod > AMBA_WORD'(2) || w_len > c_cw) s1_err_d = 1'b1;
    for (int i = 0; i < c_cw; i++) w_mask[i] = (i < w_len);
    s1_data_d = s1_err_d ? w_raw : (w_raw & w_mask);
  end

  always_comb begin
    syn_d = '0;
    w_row = '0;
    for (int r = 0; r < c_pw; r++) begin
      w_row    = h_row(s1_wm_q[1:0], r);
      syn_d[r] = ^(s1_data_q & w_row[c_cw-1:0]);
    end
    if (s1_err_q) syn_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_wm_q    <= '0;
      s1_err_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_wm_q    <= '0;
      s2_err_q   <= 1'b0;
      s2_syn_q   <= '0;
    end else begin
      if (w_accept) begin
        s1_valid_q <= 1'b1;
        s1_data_q  <= s1_data_d;
        s1_wm_q    <= work_mod;
        s1_err_q   <= s1_err_d;
      end else if (w_s1_adv) begin
        s1_valid_q <= 1'b0;
      end
      if (w_s2_adv) s2_valid_q <= s1_valid_q;
      if (w_s1_adv) begin
        s2_data_q <= s1_data_q;
        s2_wm_q   <= s1_wm_q;
        s2_err_q  <= s1_err_q;
        s2_syn_q  <= syn_d;
      end
    end
  end

  assign out_valid    = s2_valid_q;
  assign data_out     = s2_data_q;
  assign s_vector     = s2_syn_q;
  assign work_mod_out = s2_wm_q;
  assign mode_err     = s2_err_q;

endmodule
`default_nettype wire
